// File: rtl/com_slink_rxarb_if.sv
// Slink receive arbiter bundle: per-channel request/byte streams, one-hot grant,
// merged 8-bit output stream, and arbiter status/error flags.
// Ports: master = channel sources + merged-stream sink, slave = arbiter.
interface com_slink_rxarb_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]   ch_mask;
  logic [NUM_CH-1:0]   ch_req;
  logic [NUM_CH-1:0]   ch_gnt;
  logic [NUM_CH-1:0]   ch_dval;
  logic [NUM_CH-1:0]   ch_sop;
  logic [NUM_CH-1:0]   ch_eop;
  logic [8*NUM_CH-1:0] ch_data;
  logic                out_dval;
  logic                out_sop;
  logic                out_eop;
  logic [7:0]          out_data;
  logic                arb_busy;
  logic [2:0]          arb_cur_ch;
  logic                err_len;
  logic                err_to;

  modport slave (
    input  ch_mask, ch_req, ch_dval, ch_sop, ch_eop, ch_data,
    output ch_gnt, out_dval, out_sop, out_eop, out_data,
    output arb_busy, arb_cur_ch, err_len, err_to
  );

  modport master (
    output ch_mask, ch_req, ch_dval, ch_sop, ch_eop, ch_data,
    input  ch_gnt, out_dval, out_sop, out_eop, out_data,
    input  arb_busy, arb_cur_ch, err_len, err_to
  );
endinterface

// File: rtl/com_slink_rxarb.sv
// Packet-atomic round-robin merge of NUM_CH byte streams into one dval/sop/eop/data stream.
// Latency: 1 cycle from granted channel byte to out_*; grant 1 cycle after request seen in IDLE.
// Backpressure: none downstream; channels are throttled only by ch_gnt, one whole packet per grant.
// Ports: clk_wr, rst_wr (async active-low), bus (slave side of com_slink_rxarb_if):
//   ch_mask/ch_req/ch_dval/ch_sop/ch_eop/ch_data in, ch_gnt out, out_* merged stream,
//   arb_busy/arb_cur_ch status, err_len/err_to one-cycle error pulses.
module com_slink_rxarb #(
  parameter int NUM_CH  = 4,
  parameter int MAX_LEN = 2048,
  parameter int IDLE_TO = 255
) (
  input  logic             clk_wr,
  input  logic             rst_wr,
  com_slink_rxarb_if.slave bus
);

  localparam int BW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(IDLE_TO + 1);
  localparam logic [BW-1:0] LEN_LAST = BW'(MAX_LEN - 1);
  localparam logic [IW-1:0] TO_LAST  = IW'(IDLE_TO - 1);
  localparam logic [2:0]    PTR_RST  = 3'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        ptr;       // last granted channel; reset value gives channel 0 first priority
  logic [2:0]        cur_ch;    // visible copy of ptr, resets to 0
  logic [BW-1:0]     byte_cnt;
  logic [IW-1:0]     idle_cnt;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] gnt;
  logic              busy;
  logic              hi_vld;
  logic              lo_vld;
  logic [2:0]        hi_idx;
  logic [2:0]        lo_idx;
  logic              pick_vld;
  logic [2:0]        pick_idx;
  logic              g_dval;
  logic              g_eop;
  logic [7:0]        g_data;
  logic              len_hit;
  logic              to_hit;
  logic              xfer_end;
  logic              fwd_dval;
  logic              fwd_sop;
  logic              fwd_eop;
  logic [7:0]        fwd_data;
  logic              len_err;
  logic              to_err;

  assign elig = bus.ch_req & bus.ch_mask;

  // Round robin from ptr+1: channels above ptr win over those at or below it;
  // within each half the lowest index wins (descending loop, last write sticks).
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (elig[c]) begin
        if (c > int'(ptr)) begin
          hi_vld = 1'b1;
          hi_idx = 3'(c);
        end else begin
          lo_vld = 1'b1;
          lo_idx = 3'(c);
        end
      end
    end
    pick_vld = hi_vld | lo_vld;
    pick_idx = hi_vld ? hi_idx : lo_idx;
  end

  // Only the granted channel's inputs are looked at.
  always_comb begin
    g_dval = 1'b0;
    g_eop  = 1'b0;
    g_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cur_ch == 3'(c)) begin
        g_dval = bus.ch_dval[c];
        g_eop  = bus.ch_eop[c];
        g_data = bus.ch_data[8*c +: 8];
      end
    end
  end

  // MAX_LEN-th byte without eop is closed by force; a byte arriving on the
  // would-be expiry cycle takes precedence over the timeout.
  assign len_hit  = g_dval && !g_eop && (byte_cnt == LEN_LAST);
  assign to_hit   = !g_dval && (idle_cnt == TO_LAST);
  assign xfer_end = (state == XFER) && ((g_dval && g_eop) || len_hit || to_hit);

  // FSM: state register
  always_ff @(posedge clk_wr or negedge rst_wr) begin
    if (!rst_wr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = XFER;
      XFER:    if (xfer_end) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    gnt  = '0;
    busy = (state != IDLE);
    if (state == XFER) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cur_ch == 3'(c)) gnt[c] = 1'b1;
      end
    end
  end

  // Datapath: grant capture, counters, registered output stream.
  always_ff @(posedge clk_wr or negedge rst_wr) begin
    if (!rst_wr) begin
      ptr      <= PTR_RST;
      cur_ch   <= '0;
      byte_cnt <= '0;
      idle_cnt <= '0;
      fwd_dval <= 1'b0;
      fwd_sop  <= 1'b0;
      fwd_eop  <= 1'b0;
      fwd_data <= '0;
      len_err  <= 1'b0;
      to_err   <= 1'b0;
    end else begin
      fwd_dval <= 1'b0;
      fwd_sop  <= 1'b0;
      fwd_eop  <= 1'b0;
      fwd_data <= '0;
      len_err  <= 1'b0;
      to_err   <= 1'b0;
      if (state == IDLE) begin
        if (pick_vld) begin
          ptr      <= pick_idx;
          cur_ch   <= pick_idx;
          byte_cnt <= '0;
          idle_cnt <= '0;
        end
      end else if (state == XFER) begin
        if (g_dval) begin
          fwd_dval <= 1'b1;
          // sop is regenerated from position: first byte of the grant only
          fwd_sop  <= (byte_cnt == '0);
          fwd_eop  <= g_eop | len_hit;
          fwd_data <= g_data;
          len_err  <= len_hit;
          byte_cnt <= byte_cnt + 1'b1;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
          if (to_hit) begin
            // zero-data terminator; downstream CRC rejects the truncated packet
            fwd_dval <= 1'b1;
            fwd_eop  <= 1'b1;
            to_err   <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.ch_gnt     = gnt;
  assign bus.arb_busy   = busy;
  assign bus.arb_cur_ch = cur_ch;
  assign bus.out_dval   = fwd_dval;
  assign bus.out_sop    = fwd_sop;
  assign bus.out_eop    = fwd_eop;
  assign bus.out_data   = fwd_data;
  assign bus.err_len    = len_err;
  assign bus.err_to     = to_err;

endmodule

// File: tb/tb_com_slink_rxarb.sv
// Self-checking bench for com_slink_rxarb: cycle table for a single packet,
// then channel-model sequences for round robin, length limit, timeout, mask/sop
// repair and reset mid-packet.
module tb_com_slink_rxarb;
  localparam int NCH  = 4;
  localparam int MLEN = 16;
  localparam int ITO  = 8;

  logic clk_wr = 1'b0;
  logic rst_wr;
  always #5 clk_wr = ~clk_wr;

  com_slink_rxarb_if #(.NUM_CH(NCH)) bus ();

  com_slink_rxarb #(.NUM_CH(NCH), .MAX_LEN(MLEN), .IDLE_TO(ITO)) dut (
    .clk_wr (clk_wr),
    .rst_wr (rst_wr),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- cycle table (channel 1 only) ----------------
  typedef struct {
    logic [3:0] req;
    logic       dval, sop, eop;
    logic [7:0] data;
    logic [3:0] gnt;
    logic       busy;
    logic [2:0] cur;
    logic       odv, osop, oeop;
    logic [7:0] odat;
  } vec_t;

  function automatic vec_t mkv(int req, int dv, int sp, int ep, int dat, int gnt, int busy,
                               int cur, int odv, int osop, int oeop, int odat);
    vec_t v;
    v.req = 4'(req); v.dval = 1'(dv); v.sop = 1'(sp); v.eop = 1'(ep); v.data = 8'(dat);
    v.gnt = 4'(gnt); v.busy = 1'(busy); v.cur = 3'(cur);
    v.odv = 1'(odv); v.osop = 1'(osop); v.oeop = 1'(oeop); v.odat = 8'(odat);
    return v;
  endfunction

  // ---------------- channel model + monitor ----------------
  typedef struct packed {
    logic [7:0] data;
    logic       sop, eop, el, et;
    logic [2:0] ch;
  } orec_t;

  function automatic orec_t mkrec(int data, int sp, int ep, int el, int et, int ch);
    orec_t r;
    r.data = 8'(data); r.sop = 1'(sp); r.eop = 1'(ep); r.el = 1'(el); r.et = 1'(et); r.ch = 3'(ch);
    return r;
  endfunction

  int npkts[NCH], done_pkts[NCH], plen[NCH], pos[NCH], stall_at[NCH], tail[NCH], fall_pos[NCH];
  bit no_eop[NCH], rude[NCH], sop_first[NCH], sop2[NCH], prev_gnt[NCH], mon_prev[NCH];
  logic [NCH-1:0] mask_v;
  orec_t out_q[$];
  int    out_cyc[$];
  int    gnt_q[$];
  int    viol;
  bit    prev_eop;
  int    cyc = 0;

  task automatic clear_obs();
    out_q.delete(); out_cyc.delete(); gnt_q.delete();
    viol = 0; prev_eop = 1'b0;
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      npkts[c] = 0; done_pkts[c] = 0; plen[c] = 0; pos[c] = 0; stall_at[c] = -1;
      tail[c] = 0; fall_pos[c] = -1; no_eop[c] = 0; rude[c] = 0; sop_first[c] = 1;
      sop2[c] = 0; prev_gnt[c] = 0; mon_prev[c] = 0;
    end
    mask_v = '1;
    clear_obs();
    bus.ch_mask = '1; bus.ch_req = '0; bus.ch_dval = '0;
    bus.ch_sop = '0; bus.ch_eop = '0; bus.ch_data = '0;
  endtask

  task automatic model_drive();
    logic [NCH-1:0]   gv, rq, dv, sp, ep;
    logic [8*NCH-1:0] dt;
    gv = bus.ch_gnt; rq = '0; dv = '0; sp = '0; ep = '0; dt = '0;
    for (int c = 0; c < NCH; c++) begin
      if (prev_gnt[c] && !gv[c]) begin
        done_pkts[c]++;
        fall_pos[c] = pos[c];
        tail[c] = rude[c] ? plen[c] - pos[c] : 0;
        pos[c] = 0;
      end
      prev_gnt[c] = gv[c];
      if (gv[c] && pos[c] < plen[c] && pos[c] != stall_at[c]) begin
        dv[c] = 1'b1;
        dt[8*c +: 8] = 8'(16*c + pos[c] + 1);
        sp[c] = (pos[c] == 0) ? sop_first[c] : (pos[c] == 1 && sop2[c]);
        ep[c] = (pos[c] == plen[c] - 1) && !no_eop[c];
        pos[c]++;
      end else if (tail[c] > 0) begin
        // ungranted junk: must never reach the output
        dv[c] = 1'b1; sp[c] = 1'b1; ep[c] = 1'b1; dt[8*c +: 8] = 8'hEE;
        tail[c]--;
      end
      rq[c] = done_pkts[c] < npkts[c];
    end
    bus.ch_mask = mask_v; bus.ch_req = rq; bus.ch_dval = dv;
    bus.ch_sop = sp; bus.ch_eop = ep; bus.ch_data = dt;
  endtask

  task automatic monitor();
    logic [NCH-1:0] gv;
    gv = bus.ch_gnt;
    for (int c = 0; c < NCH; c++) begin
      if (gv[c] && !mon_prev[c]) gnt_q.push_back(c);
      mon_prev[c] = gv[c];
    end
    if ($countones(gv) > 1) viol++;
    if ((bus.err_len || bus.err_to) && !bus.out_dval) viol++;
    if (prev_eop && bus.out_dval) viol++;
    if (bus.out_dval) begin
      out_q.push_back({bus.out_data, bus.out_sop, bus.out_eop, bus.err_len, bus.err_to, bus.arb_cur_ch});
      out_cyc.push_back(cyc);
    end
    prev_eop = bus.out_dval && bus.out_eop;
  endtask

  task automatic cycle();
    @(posedge clk_wr); #1;
    model_drive();
    @(negedge clk_wr);
    monitor();
    cyc++;
  endtask

  function automatic bit chans_done(logic [NCH-1:0] set);
    bit ok = 1'b1;
    for (int c = 0; c < NCH; c++) if (set[c] && done_pkts[c] < npkts[c]) ok = 1'b0;
    return ok;
  endfunction

  task automatic run_until(input logic [NCH-1:0] set, input int budget, input string name);
    int n = 0;
    while (!chans_done(set) && n < budget) begin cycle(); n++; end
    repeat (6) cycle();
    check({name, "_done"}, 64'(chans_done(set)), 64'd1);
  endtask

  task automatic exp_byte(input string name, input int idx, input orec_t exp);
    if (idx < out_q.size()) check($sformatf("%s[%0d]", name, idx), 64'(out_q[idx]), 64'(exp));
    else check($sformatf("%s[%0d]_present", name, idx), 64'(out_q.size()), 64'(idx + 1));
  endtask

  function automatic int gq(int i);
    return (i < gnt_q.size()) ? gnt_q[i] : -1;
  endfunction

  task automatic do_reset();
    rst_wr = 1'b0;
    model_clear();
    repeat (2) @(negedge clk_wr);
    rst_wr = 1'b1;
  endtask

  vec_t tv[8];
  int   order[6];

  initial begin
    rst_wr = 1'b0;
    tv[0] = mkv(2, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0);
    tv[1] = mkv(2, 1, 1, 0, 'h11,  2, 1, 1, 0, 0, 0, 0);
    tv[2] = mkv(2, 1, 0, 0, 'h12,  2, 1, 1, 1, 1, 0, 'h11);
    tv[3] = mkv(2, 1, 0, 0, 'h13,  2, 1, 1, 1, 0, 0, 'h12);
    tv[4] = mkv(2, 1, 0, 0, 'h14,  2, 1, 1, 1, 0, 0, 'h13);
    tv[5] = mkv(0, 1, 0, 1, 'h15,  2, 1, 1, 1, 0, 0, 'h14);
    tv[6] = mkv(0, 0, 0, 0, 0,     0, 1, 1, 1, 0, 1, 'h15);
    tv[7] = mkv(0, 0, 0, 0, 0,     0, 0, 1, 0, 0, 0, 0);

    // ---- reset state ----
    do_reset();
    check("reset_outputs",
          {bus.ch_gnt, bus.arb_busy, bus.arb_cur_ch, bus.out_dval, bus.out_sop, bus.out_eop,
           bus.out_data, bus.err_len, bus.err_to}, 64'd0);

    // ---- single packet on ch1, cycle table ----
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_wr); #1;
      bus.ch_req  = tv[i].req;
      bus.ch_dval = {2'b00, tv[i].dval, 1'b0};
      bus.ch_sop  = {2'b00, tv[i].sop, 1'b0};
      bus.ch_eop  = {2'b00, tv[i].eop, 1'b0};
      bus.ch_data = {16'h0000, tv[i].data, 8'h00};
      @(negedge clk_wr);
      check($sformatf("table_row%0d", i),
            {bus.ch_gnt, bus.arb_busy, bus.arb_cur_ch, bus.out_dval, bus.out_sop, bus.out_eop,
             bus.out_data, bus.err_len, bus.err_to},
            {tv[i].gnt, tv[i].busy, tv[i].cur, tv[i].odv, tv[i].osop, tv[i].oeop, tv[i].odat, 2'b00});
    end

    // ---- round robin: ch0, ch2, ch3 with two 3-byte packets each ----
    do_reset();
    npkts[0] = 2; plen[0] = 3;
    npkts[2] = 2; plen[2] = 3;
    npkts[3] = 2; plen[3] = 3;
    run_until(4'b1101, 400, "rr");
    order = '{0, 2, 3, 0, 2, 3};
    check("rr_ngrants", 64'(gnt_q.size()), 64'd6);
    for (int p = 0; p < 6; p++) begin
      check($sformatf("rr_gnt_order[%0d]", p), 64'(gq(p)), 64'(order[p]));
      for (int b = 0; b < 3; b++)
        exp_byte("rr_byte", 3*p + b, mkrec(16*order[p] + b + 1, b == 0, b == 2, 0, 0, order[p]));
    end
    check("rr_protocol_viol", 64'(viol), 64'd0);

    // ---- length limit: ch0 streams 20 bytes without eop, keeps going after gnt drops ----
    do_reset();
    npkts[0] = 1; plen[0] = 20; no_eop[0] = 1; rude[0] = 1;
    run_until(4'b0001, 200, "len");
    check("len_nbytes", 64'(out_q.size()), 64'd16);
    for (int b = 0; b < 16; b++)
      exp_byte("len_byte", b, mkrec(b + 1, b == 0, b == 15, b == 15, 0, 0));
    check("len_gnt_fall_after_byte", 64'(fall_pos[0]), 64'd16);
    check("len_protocol_viol", 64'(viol), 64'd0);

    // ---- eop exactly on the MAX_LEN-th byte is a normal end ----
    clear_obs();
    npkts[1] = 1; plen[1] = 16;
    run_until(4'b0010, 200, "maxlen");
    check("maxlen_nbytes", 64'(out_q.size()), 64'd16);
    exp_byte("maxlen_byte", 0, mkrec('h11, 1, 0, 0, 0, 1));
    exp_byte("maxlen_byte", 15, mkrec('h20, 0, 1, 0, 0, 1));

    // ---- timeout: ch2 sends 3 bytes then stalls; ch3 waits ----
    do_reset();
    npkts[2] = 1; plen[2] = 5; stall_at[2] = 3;
    npkts[3] = 1; plen[3] = 2;
    run_until(4'b1100, 200, "to");
    check("to_gnt_first", 64'(gq(0)), 64'd2);
    check("to_gnt_second", 64'(gq(1)), 64'd3);
    check("to_nbytes", 64'(out_q.size()), 64'd6);
    exp_byte("to_byte", 0, mkrec('h21, 1, 0, 0, 0, 2));
    exp_byte("to_byte", 1, mkrec('h22, 0, 0, 0, 0, 2));
    exp_byte("to_byte", 2, mkrec('h23, 0, 0, 0, 0, 2));
    exp_byte("to_byte", 3, mkrec('h00, 0, 1, 0, 1, 2));
    exp_byte("to_byte", 4, mkrec('h31, 1, 0, 0, 0, 3));
    exp_byte("to_byte", 5, mkrec('h32, 0, 1, 0, 0, 3));
    if (out_cyc.size() >= 4) check("to_idle_cycles", 64'(out_cyc[3] - out_cyc[2]), 64'd8);
    else check("to_idle_cycles_present", 64'(out_cyc.size()), 64'd4);
    check("to_protocol_viol", 64'(viol), 64'd0);

    // ---- mask and sop repair: ch1 masked, ch3 sop on byte 2 instead of byte 1 ----
    do_reset();
    mask_v = 4'b1101;
    npkts[1] = 1; plen[1] = 2;
    npkts[3] = 1; plen[3] = 3; sop_first[3] = 0; sop2[3] = 1;
    run_until(4'b1000, 200, "mask");
    repeat (10) cycle();
    check("mask_ngrants", 64'(gnt_q.size()), 64'd1);
    check("mask_gnt_ch", 64'(gq(0)), 64'd3);
    exp_byte("mask_byte", 0, mkrec('h31, 1, 0, 0, 0, 3));
    exp_byte("mask_byte", 1, mkrec('h32, 0, 0, 0, 0, 3));
    exp_byte("mask_byte", 2, mkrec('h33, 0, 1, 0, 0, 3));

    // ---- reset mid-packet: ch2 10-byte packet, reset at output byte 3 ----
    do_reset();
    npkts[2] = 1; plen[2] = 10;
    begin
      int n = 0;
      while (out_q.size() < 3 && n < 100) begin cycle(); n++; end
    end
    check("rst_reach_byte3", 64'(out_q.size()), 64'd3);
    exp_byte("rst_pre_byte", 2, mkrec('h23, 0, 0, 0, 0, 2));
    #1 rst_wr = 1'b0;
    #1;
    check("rst_async_clear",
          {bus.ch_gnt, bus.arb_busy, bus.arb_cur_ch, bus.out_dval, bus.out_sop, bus.out_eop,
           bus.out_data, bus.err_len, bus.err_to}, 64'd0);
    model_clear();
    npkts[0] = 1; plen[0] = 2;
    npkts[2] = 1; plen[2] = 2;
    repeat (2) @(negedge clk_wr);
    rst_wr = 1'b1;
    run_until(4'b0101, 200, "rst_after");
    check("rst_first_gnt", 64'(gq(0)), 64'd0);
    check("rst_second_gnt", 64'(gq(1)), 64'd2);
    exp_byte("rst_after_byte", 0, mkrec('h01, 1, 0, 0, 0, 0));
    check("rst_protocol_viol", 64'(viol), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/com_slink_rxarb.md
Name: com_slink_rxarb

Overview:
- Packet-atomic round-robin arbiter in the slink receive path, on the write side of the receive packet FIFO.
- Merges up to NUM_CH per-channel byte streams into the single 8-bit dval/sop/eop/data stream that feeds the 8-to-16 packer and packet FIFO.
- Each channel is granted for exactly one whole packet.
- Enforces a length limit and an inter-byte timeout, so a broken channel cannot hold the merged stream.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
MAX_LEN, 2048, maximum bytes per packet, including the eop byte
IDLE_TO, 255, maximum consecutive cycles with no dval while granted (1..65535)

Ports:
clk_wr  input  1  write-side clock
rst_wr  input  1  asynchronous, active-low reset
ch_mask  input  NUM_CH  per-channel enable; 0 = channel never granted
ch_req  input  NUM_CH  channel holds a complete packet and requests a grant
ch_gnt  output  NUM_CH  one-hot grant; the channel may stream while it is high
ch_dval  input  NUM_CH  per-channel byte valid
ch_sop  input  NUM_CH  per-channel start of packet, qualified by dval
ch_eop  input  NUM_CH  per-channel end of packet, qualified by dval
ch_data  input  8*NUM_CH  per-channel byte; channel i occupies bits [8i+7:8i]
out_dval  output  1  merged byte valid
out_sop  output  1  merged start of packet
out_eop  output  1  merged end of packet
out_data  output  8  merged byte
arb_busy  output  1  high in every state other than IDLE
arb_cur_ch  output  3  index of the granted channel, or of the last granted channel while idle
err_len  output  1  one-cycle pulse when the length limit forces an eop
err_to  output  1  one-cycle pulse when the inter-byte timeout fires

Behaviour:
- Reset values:
  - All outputs are 0.
  - The round-robin pointer is set so that channel 0 has first priority.
  - The byte counter and the idle counter are 0. The state is IDLE.
- States: IDLE, XFER, GAP.
- IDLE:
  - The eligible set is ch_req & ch_mask.
  - If the set is non-empty, choose the first eligible channel starting at last_granted+1, wrapping modulo NUM_CH.
  - On the next edge: the chosen ch_gnt bit goes high, arb_cur_ch updates, the state goes to XFER, and both counters clear.
- XFER, forwarding:
  - Only the granted channel's inputs are sampled; all other channels' inputs are ignored.
  - Forwarding latency is 1 cycle: out_* are registered copies of the granted channel's dval/sop/eop/data.
  - out_* are zero on any cycle where dval is not forwarded.
- XFER, sop handling:
  - out_sop is forced to 1 on the first forwarded byte of the grant, even if ch_sop is 0.
  - A ch_sop on any later byte is suppressed.
- XFER, counters:
  - Every forwarded byte increments the byte counter.
  - The idle counter increments on each cycle with no dval and clears on any dval.
- XFER, normal end: on the cycle where ch_eop and ch_dval are both high, the byte is forwarded with out_eop=1. On the next edge ch_gnt drops and the state goes to GAP.
- XFER, length overflow:
  - If the MAX_LEN-th byte arrives without ch_eop, it is forwarded with out_eop forced to 1.
  - err_len pulses together with that out_eop.
  - ch_gnt drops on the next edge and the state goes to GAP.
  - Any further bytes from that channel are ignored.
- XFER, timeout:
  - When the idle counter reaches IDLE_TO, the arbiter emits one terminating byte: out_dval=1, out_eop=1, out_data=8'h00.
  - err_to pulses in the same cycle.
  - ch_gnt drops and the state goes to GAP. The downstream CRC check rejects the truncated packet.
- GAP: exactly one cycle with out_dval=0, then IDLE. This guarantees at least one idle cycle between merged packets.
- Boundary conditions:
  - eop on the MAX_LEN-th byte is a normal end; err_len stays 0.
  - A dval on the cycle the idle counter would expire clears the counter, so the timeout does not fire.
  - ch_req or ch_mask falling during XFER does not abort the transfer.
  - A channel whose mask bit is 0 is skipped, but the pointer still rotates past it.
  - A requester that is the only eligible channel is re-granted after GAP, one packet per grant.
  - The idle/transfer state is not affected by dval arriving while not granted; such bytes are ignored.
- Reset mid-packet: all outputs clear immediately and the state returns to IDLE. No eop is emitted for the interrupted packet.

Test Plan:
- Single packet: ch1 requests and sends 5 bytes 0x11..0x15 (sop on the first, eop on the last) -> ch_gnt=4'b0010 one cycle after the request; out bytes 0x11..0x15 each one cycle late; out_sop on 0x11 only, out_eop on 0x15 only; one GAP cycle.
- Round robin: ch0, ch2 and ch3 all request continuously, 3-byte packets -> grant order 0, 2, 3, 0, ...; packets never interleave; at least one idle cycle between packets.
- Length limit: MAX_LEN=16, ch0 sends 20 bytes with no eop -> out_eop and err_len on output byte 16; bytes 17..20 dropped; ch_gnt low the cycle after byte 16.
- Timeout: IDLE_TO=8, ch2 sends 3 bytes then stalls -> after 8 idle cycles, one output byte with out_data=0x00, out_dval=1, out_eop=1, and err_to pulses; the next requester is granted after GAP.
- Mask and sop repair: ch_mask=4'b1101, ch1 and ch3 request, ch3's first byte has ch_sop=0 and byte 2 has ch_sop=1 -> ch1 is never granted; ch3's first byte has out_sop=1 and byte 2 has out_sop=0.
- Reset mid-packet: rst_wr asserted at byte 3 of a 10-byte packet -> out_* and ch_gnt go to 0 immediately; after release, first grant goes to channel 0 when it is requesting.
